uart_apb_ctrl: RTL and testbench
================================

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, meaning the TX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15, meaning the maximum number of cycles to wait for tx_busy to rise after a launch.
REQ-003 SHALL have ports, in this order:
- PCLK  in  1  clock.
- PRESETn  in  1  reset; asynchronous, active-high (port name retained, polarity is high).
- PSELx  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  address; only bits [3:2] are decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- tx_data  out  8  byte to the transmitter.
- tx_wr_en  out  1  one-cycle launch pulse to the transmitter.
- tx_busy  in  1  transmitter shifting.
- rx_data  in  8  received byte.
- rx_rdy  in  1  receiver holds a byte.
- rx_rdy_clr  out  1  one-cycle acknowledge to the receiver.
- irq  out  1  interrupt.

Function
REQ-004 SHALL use this register map on PADDR[3:2]:
- 0 TXDATA: W pushes PWDATA[7:0]; R returns 0.
- 1 RXDATA: R returns {24'b0, rx_byte} and clears rx_valid.
- 2 STATUS: RO; bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_ovr, bit4 tx_active, bit5 tx_drop.
- 3 CTRL: RW bits [2:0] = tx_en, rx_irq_en, tx_irq_en; writing 1 to bit4 clears rx_ovr and tx_drop (bit4 is not stored).
REQ-005 SHALL assert PREADY combinationally whenever PSELx && PENABLE, giving zero wait states; PREADY SHALL be 0 otherwise.
REQ-006 SHALL apply register side effects (push, RX clear, CTRL update) only in the cycle where PSELx && PENABLE && PREADY.
REQ-007 SHALL drive PRDATA combinationally from the decoded register during the access phase, and 0 otherwise.
REQ-008 SHALL drop a TXDATA write when the FIFO is full (full evaluated before any same-cycle pop), leave FIFO contents unchanged, and set sticky tx_drop.
REQ-009 SHALL let a push and a pop in the same cycle both take effect; the count stays unchanged.
REQ-010 SHALL implement the TX FSM with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; tx_active=1 in any state other than IDLE.
REQ-011 SHALL move from IDLE to LAUNCH when tx_en && !tx_empty && !tx_busy.
REQ-012 In LAUNCH, SHALL drive tx_data with the FIFO head, pulse tx_wr_en for exactly one cycle, pop the FIFO, then go to WAIT_BUSY.
REQ-013 In WAIT_BUSY, SHALL go to WAIT_DONE when tx_busy=1, or return to IDLE after BUSY_TIMEOUT cycles with tx_busy=0 (cycle counter width sized from BUSY_TIMEOUT).
REQ-014 In WAIT_DONE, SHALL return to IDLE when tx_busy=0.
REQ-015 SHALL hold tx_data stable from LAUNCH until the next launch.
REQ-016 SHALL NOT abort a byte already launched when tx_en is cleared mid-byte; the FSM finishes WAIT_DONE and then idles.
REQ-017 SHALL implement RX capture with states RX_IDLE and RX_ACK.
REQ-018 In RX_IDLE with rx_rdy=1:
- if rx_valid=0, capture rx_data into rx_byte and set rx_valid;
- if rx_valid=1, discard the new byte and set sticky rx_ovr;
- in both cases pulse rx_rdy_clr for one cycle and go to RX_ACK.
REQ-019 SHALL ignore rx_rdy in RX_ACK and return to RX_IDLE the next cycle.
REQ-020 When an RXDATA read coincides with a capture, SHALL return the old byte, store the new byte, keep rx_valid=1, and not set rx_ovr.
REQ-021 SHALL compute irq = (rx_irq_en && rx_valid) || (tx_irq_en && tx_empty && !tx_active), registered (one cycle latency).

Reset
REQ-022 SHALL reset asynchronously on PRESETn=1 with this state:
- TX FSM = IDLE; RX FSM = RX_IDLE;
- FIFO empty, pointers 0;
- CTRL = 0; rx_byte = 0; rx_valid, rx_ovr, tx_drop = 0;
- tx_data = 0; tx_wr_en = 0; rx_rdy_clr = 0; irq = 0.
REQ-023 SHALL discard a byte in flight when reset occurs mid-operation; no launch pulse follows reset release unless REQ-011 holds.

Structure
REQ-024 Package uart_ctrl_pkg SHALL hold the register offsets, STATUS/CTRL bit positions, and TX/RX FSM state encodings.
REQ-025 The FIFO SHALL be sub-module uart_tx_fifo (parameter DEPTH; push, pop, full, empty, head outputs).

Verification
REQ-026 Reset then STATUS read -> PRDATA=0x02, PREADY=1 in the access phase, irq=0.
REQ-027 CTRL=0x1; write 0x41, 0x42; tx_busy high 3 cycles after each launch for 20 cycles -> two tx_wr_en pulses carrying 0x41 then 0x42, second pulse only after tx_busy falls.
REQ-028 CTRL=0x0; five TXDATA writes with TX_DEPTH=4 -> STATUS=0x21 (full, tx_drop); set CTRL=0x1 -> first four bytes sent in order; write CTRL=0x11 -> tx_drop clears.
REQ-029 rx_rdy with rx_data=0x5A -> one rx_rdy_clr pulse, STATUS bit2=1; second rx_rdy with 0xA5 before any read -> rx_ovr=1; RXDATA read -> 0x5A.
REQ-030 CTRL=0x2, capture 0x33 -> irq=1 one cycle later; RXDATA read -> irq=0 the following cycle.
REQ-031 tx_wr_en issued with tx_busy held 0 -> FSM returns to IDLE after 15 cycles; PRESETn pulsed mid-WAIT_DONE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_ctrl_pkg
// Brief   : Register offsets, STATUS/CTRL bit positions and FSM state
//           encodings shared by the APB UART controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_ctrl_pkg;

  // Register offsets, decoded from PADDR[3:2]
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_VALID  = 2;
  localparam int STAT_RX_OVR    = 3;
  localparam int STAT_TX_ACTIVE = 4;
  localparam int STAT_TX_DROP   = 5;

  // CTRL bit positions; CTRL_CLR_STICKY is write-only and never stored
  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_IRQ_EN  = 1;
  localparam int CTRL_TX_IRQ_EN  = 2;
  localparam int CTRL_CLR_STICKY = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_fifo
// Brief   : Byte FIFO feeding the transmitter. A push into a full FIFO is
//           ignored even if a pop happens in the same cycle; a simultaneous
//           push and pop both take effect.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_apb_ctrl.sv
//------------------------------------------------------------------------------
// Module  : uart_apb_ctrl
// Brief   : Zero-wait-state APB register front end for a byte UART: TX FIFO
//           with launch/handshake FSM, single-byte RX capture with overrun
//           detection, and a registered interrupt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_apb_ctrl #(
  parameter int TX_DEPTH     = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_rdy_clr,
  output logic        irq
);

  import uart_ctrl_pkg::*;

  localparam int            TW       = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(BUSY_TIMEOUT - 1);

  tx_state_t     tx_state;
  rx_state_t     rx_state;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    ctrl_reg;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ovr;
  logic          tx_drop;

  logic          access;
  logic          wr_xfer;
  logic          rd_xfer;
  logic [1:0]    addr;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [7:0]    tx_head;
  logic          tx_active;
  logic          rx_read;
  logic          ctrl_write;
  logic          clr_sticky;
  logic [31:0]   status_word;
  logic          unused_bits;

  // APB decode; PREADY is the access phase itself, so every access completes
  assign access     = PSELx && PENABLE;
  assign PREADY     = access;
  assign addr       = PADDR[3:2];
  assign wr_xfer    = access && PREADY && PWRITE;
  assign rd_xfer    = access && PREADY && !PWRITE;
  assign tx_push    = wr_xfer && (addr == ADDR_TXDATA);
  assign ctrl_write = wr_xfer && (addr == ADDR_CTRL);
  assign clr_sticky = ctrl_write && PWDATA[CTRL_CLR_STICKY];
  assign rx_read    = rd_xfer && (addr == ADDR_RXDATA);
  assign tx_pop     = (tx_state == LAUNCH);
  assign tx_active  = (tx_state != IDLE);
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8]};

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (PCLK),
    .rst   (PRESETn),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (PWDATA[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // STATUS word assembly
  always_comb begin
    status_word                 = '0;
    status_word[STAT_TX_FULL]   = tx_full;
    status_word[STAT_TX_EMPTY]  = tx_empty;
    status_word[STAT_RX_VALID]  = rx_valid;
    status_word[STAT_RX_OVR]    = rx_ovr;
    status_word[STAT_TX_ACTIVE] = tx_active;
    status_word[STAT_TX_DROP]   = tx_drop;
  end

  // Read mux, live only during the access phase
  always_comb begin
    PRDATA = '0;
    if (access) begin
      case (addr)
        ADDR_RXDATA: PRDATA = {24'b0, rx_byte};
        ADDR_STATUS: PRDATA = status_word;
        ADDR_CTRL:   PRDATA = {29'b0, ctrl_reg};
        default:     PRDATA = '0;
      endcase
    end
  end

  // CTRL register and sticky TX drop flag (a new drop wins over a clear)
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      ctrl_reg <= '0;
      tx_drop  <= 1'b0;
    end else begin
      if (ctrl_write) ctrl_reg <= PWDATA[2:0];
      if (tx_push && tx_full) tx_drop <= 1'b1;
      else if (clr_sticky)    tx_drop <= 1'b0;
    end
  end

  // TX FSM: launch one byte, then wait for the transmitter to take and finish it
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      tx_state <= IDLE;
      tx_data  <= '0;
      tx_wr_en <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (ctrl_reg[CTRL_TX_EN] && !tx_empty && !tx_busy) begin
            tx_data  <= tx_head;
            tx_wr_en <= 1'b1;
            tx_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_wr_en <= 1'b0;
          wait_cnt <= '0;
          tx_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy)                   tx_state <= WAIT_DONE;
          else if (wait_cnt == CNT_LAST) tx_state <= IDLE;
          else                           wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_DONE: begin
          // tx_en is deliberately not checked: a launched byte always completes
          if (!tx_busy) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX FSM: capture or flag overrun, acknowledge, then ignore rx_rdy for a cycle
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      rx_state   <= RX_IDLE;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_ovr     <= 1'b0;
      rx_rdy_clr <= 1'b0;
    end else begin
      rx_rdy_clr <= 1'b0;
      if (rx_read)    rx_valid <= 1'b0;
      if (clr_sticky) rx_ovr   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_rdy) begin
            rx_rdy_clr <= 1'b1;
            rx_state   <= RX_ACK;
            // A read in this same cycle frees the holding register
            if (!rx_valid || rx_read) begin
              rx_byte  <= rx_data;
              rx_valid <= 1'b1;
            end else begin
              rx_ovr <= 1'b1;
            end
          end
        end
        RX_ACK:  rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Registered interrupt
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) irq <= 1'b0;
    else irq <= (ctrl_reg[CTRL_RX_IRQ_EN] && rx_valid) ||
                (ctrl_reg[CTRL_TX_IRQ_EN] && tx_empty && !tx_active);
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_apb_ctrl
// Brief   : Directed self-checking bench for uart_apb_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_apb_ctrl;

  localparam logic [31:0] A_TX   = 32'h0;
  localparam logic [31:0] A_RX   = 32'h4;
  localparam logic [31:0] A_ST   = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_rdy_clr;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Transmitter model: 0 = busy never rises, 1 = busy for 3 cycles, 2 = busy held
  int         busy_mode = 0;
  int         overlap   = 0;
  logic [7:0] launches[$];

  always #5 PCLK = ~PCLK;

  uart_apb_ctrl #(
    .TX_DEPTH     (4),
    .BUSY_TIMEOUT (15)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .tx_data    (tx_data),
    .tx_wr_en   (tx_wr_en),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .irq        (irq)
  );

  // Transmitter model: records every launched byte and answers with tx_busy
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge PCLK);
      if (tx_wr_en) begin
        launches.push_back(tx_data);
        if (tx_busy) overlap++;
        if (busy_mode != 0) begin
          @(posedge PCLK); #1;
          tx_busy = 1'b1;
          if (busy_mode == 1) begin
            repeat (3) begin
              @(negedge PCLK);
              if (tx_wr_en) overlap++;
              @(posedge PCLK);
            end
            #1;
            tx_busy = 1'b0;
          end else begin
            wait (busy_mode != 2);
            tx_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d   = PRDATA;
    rdy = PREADY;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  // Poll STATUS until the FIFO is empty and the TX FSM is idle (bounded)
  task automatic wait_tx_idle(output bit ok);
    logic [31:0] d;
    logic        r;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      apb_read(A_ST, d, r);
      if (d[1] && !d[4]) ok = 1'b1;
    end
  endtask

  // Present a byte on rx_rdy and drop it once acknowledged; counts ack pulses
  task automatic rx_send(input logic [7:0] b, output int pulses);
    pulses = 0;
    @(posedge PCLK); #1;
    rx_data = b; rx_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (rx_rdy_clr) begin
        pulses++;
        @(posedge PCLK); #1;
        rx_rdy = 1'b0;
      end
    end
    rx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    total++;
    if (irq !== 1'b0 || tx_wr_en !== 1'b0 || rx_rdy_clr !== 1'b0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: irq=%b tx_wr_en=%b rx_rdy_clr=%b tx_data=%h required 0 0 0 00",
               irq, tx_wr_en, rx_rdy_clr, tx_data);
    end
    total++;
    if (PREADY !== 1'b0 || PRDATA !== 32'h0) begin
      bad++;
      $display("FAIL idle_bus: PREADY=%b PRDATA=%h required 0 00000000", PREADY, PRDATA);
    end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h02) begin bad++; $display("FAIL reset_status: got %h required 00000002", d); end
    total++;
    if (r !== 1'b1) begin bad++; $display("FAIL reset_pready: got %b required 1", r); end
    apb_read(A_CTRL, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h required 00000000", d); end
    apb_read(A_TX, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h required 00000000", d); end
  endtask

  task automatic test_tx_basic();
    bit ok;
    busy_mode = 1; overlap = 0; launches.delete();
    apb_write(A_CTRL, 32'h1);
    apb_write(A_TX, 32'h41);
    apb_write(A_TX, 32'h42);
    wait_tx_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tx_basic_idle: got timeout required idle"); end
    total++;
    if (launches.size() != 2) begin
      bad++; $display("FAIL tx_basic_count: got %0d required 2", launches.size());
    end
    if (launches.size() >= 2) begin
      total++;
      if (launches[0] !== 8'h41) begin bad++; $display("FAIL tx_basic_byte0: got %h required 41", launches[0]); end
      total++;
      if (launches[1] !== 8'h42) begin bad++; $display("FAIL tx_basic_byte1: got %h required 42", launches[1]); end
    end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL tx_launch_while_busy: got %0d required 0", overlap); end
    apb_write(A_CTRL, 32'h5);
    repeat (2) @(negedge PCLK);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL tx_irq_on: got %b required 1", irq); end
    apb_write(A_CTRL, 32'h1);
    repeat (2) @(negedge PCLK);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL tx_irq_off: got %b required 0", irq); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    logic        r;
    logic [7:0]  exp;
    bit          ok;
    busy_mode = 1; overlap = 0; launches.delete();
    apb_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) apb_write(A_TX, 32'h10 + 32'(i));
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h21) begin bad++; $display("FAIL full_status: got %h required 00000021", d); end
    apb_write(A_CTRL, 32'h1);
    wait_tx_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL full_drain_idle: got timeout required idle"); end
    total++;
    if (launches.size() != 4) begin
      bad++; $display("FAIL full_drain_count: got %0d required 4", launches.size());
    end
    for (int i = 0; i < 4 && i < launches.size(); i++) begin
      exp = 8'h10 + 8'(i);
      total++;
      if (launches[i] !== exp) begin
        bad++; $display("FAIL full_drain_byte%0d: got %h required %h", i, launches[i], exp);
      end
    end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h22) begin bad++; $display("FAIL drained_status: got %h required 00000022", d); end
    apb_write(A_CTRL, 32'h11);
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h02) begin bad++; $display("FAIL drop_cleared: got %h required 00000002", d); end
    apb_read(A_CTRL, d, r);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL ctrl_readback: got %h required 00000001", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic        r;
    int          p;
    apb_write(A_CTRL, 32'h0);
    rx_send(8'h5A, p);
    total++;
    if (p != 1) begin bad++; $display("FAIL rx_ack_pulses: got %0d required 1", p); end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h06) begin bad++; $display("FAIL rx_valid_status: got %h required 00000006", d); end
    rx_send(8'hA5, p);
    total++;
    if (p != 1) begin bad++; $display("FAIL rx_ovr_ack_pulses: got %0d required 1", p); end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h0E) begin bad++; $display("FAIL rx_ovr_status: got %h required 0000000e", d); end
    apb_read(A_RX, d, r);
    total++;
    if (d !== 32'h5A) begin bad++; $display("FAIL rx_data_kept: got %h required 0000005a", d); end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h0A) begin bad++; $display("FAIL rx_read_clears: got %h required 0000000a", d); end
    apb_write(A_CTRL, 32'h10);
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h02) begin bad++; $display("FAIL rx_ovr_cleared: got %h required 00000002", d); end
  endtask

  task automatic test_rx_irq();
    logic [31:0] d;
    logic        r;
    apb_write(A_CTRL, 32'h2);
    @(posedge PCLK); #1;
    rx_data = 8'h33; rx_rdy = 1'b1;
    @(posedge PCLK); #1;
    rx_rdy = 1'b0;
    @(negedge PCLK);
    total++;
    if (irq !== 1'b0 || rx_rdy_clr !== 1'b1) begin
      bad++; $display("FAIL rx_irq_capture_cycle: irq=%b rx_rdy_clr=%b required 0 1", irq, rx_rdy_clr);
    end
    @(negedge PCLK);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq_rise: got %b required 1", irq); end
    apb_read(A_RX, d, r);
    total++;
    if (d !== 32'h33) begin bad++; $display("FAIL rx_irq_data: got %h required 00000033", d); end
    @(negedge PCLK);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq_latency: got %b required 1", irq); end
    @(negedge PCLK);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_fall: got %b required 0", irq); end
    apb_write(A_CTRL, 32'h0);
  endtask

  // RXDATA read in the same cycle a new byte is captured
  task automatic test_rx_collide();
    logic [31:0] d;
    logic        r;
    int          p;
    rx_send(8'h11, p);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_RX;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; rx_data = 8'h22; rx_rdy = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; rx_rdy = 1'b0;
    total++;
    if (d !== 32'h11) begin bad++; $display("FAIL collide_old_byte: got %h required 00000011", d); end
    @(negedge PCLK);
    total++;
    if (rx_rdy_clr !== 1'b1) begin bad++; $display("FAIL collide_ack: got %b required 1", rx_rdy_clr); end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h06) begin bad++; $display("FAIL collide_status: got %h required 00000006", d); end
    apb_read(A_RX, d, r);
    total++;
    if (d !== 32'h22) begin bad++; $display("FAIL collide_new_byte: got %h required 00000022", d); end
  endtask

  task automatic test_timeout_reset();
    logic [31:0] d;
    logic        r;
    bit          started;
    bit          done;
    bit          seen;
    int          act;
    int          pulses;
    busy_mode = 0; launches.delete();
    apb_write(A_CTRL, 32'h1);
    apb_write(A_TX, 32'h55);
    // STATUS read held in its access phase as a cycle-by-cycle tx_active monitor
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_ST;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    started = 1'b0; done = 1'b0; act = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge PCLK);
      if (!started) begin
        if (tx_wr_en) started = 1'b1;
      end else if (PRDATA[4]) act++;
      else done = 1'b1;
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    total++;
    if (!started || !done) begin
      bad++; $display("FAIL timeout_seen: started=%b done=%b required 1 1", started, done);
    end
    total++;
    if (act != 15) begin bad++; $display("FAIL timeout_cycles: got %0d required 15", act); end
    total++;
    if (launches.size() != 1) begin bad++; $display("FAIL timeout_launches: got %0d required 1", launches.size()); end

    busy_mode = 2;
    apb_write(A_TX, 32'h7E);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (tx_wr_en) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL hold_launch: got none required pulse"); end
    repeat (4) @(posedge PCLK);
    apb_write(A_TX, 32'h99);
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h10) begin bad++; $display("FAIL wait_done_status: got %h required 00000010", d); end
    total++;
    if (tx_data !== 8'h7E) begin bad++; $display("FAIL tx_data_stable: got %h required 7e", tx_data); end
    @(posedge PCLK); #3;
    PRESETn = 1'b1;
    #1;
    total++;
    if (tx_data !== 8'h00 || tx_wr_en !== 1'b0 || rx_rdy_clr !== 1'b0 || irq !== 1'b0 || PRDATA !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: tx_data=%h tx_wr_en=%b rx_rdy_clr=%b irq=%b PRDATA=%h required 00 0 0 0 0",
               tx_data, tx_wr_en, rx_rdy_clr, irq, PRDATA);
    end
    repeat (2) @(posedge PCLK); #1;
    PRESETn = 1'b0;
    busy_mode = 0;
    pulses = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (tx_wr_en) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL post_reset_launch: got %0d required 0", pulses); end
    apb_read(A_ST, d, r);
    total++;
    if (d !== 32'h02) begin bad++; $display("FAIL post_reset_status: got %h required 00000002", d); end
  endtask

  initial begin
    PRESETn = 1'b1;
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    rx_data = '0; rx_rdy = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    test_reset();
    test_tx_basic();
    test_fifo_full();
    test_rx_overrun();
    test_rx_irq();
    test_rx_collide();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
